pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline latch for the 5-stage CPU. It is the generalised successor to the fixed X/M latch. It carries instruction, N operand channels and an exception flag between stages. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure no longer needs a global write-enable. It supports a synchronous flush for branch/exception squash, and decodes the memory-write strobe for the downstream stage.

---
 rtl/pipe_stage_buf.sv | 189 ++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
//------------------------------------------------------------------------------
// pipe_stage_buf
//
// Parametrised inter-stage pipeline latch for the 5-stage CPU. Carries one
// instruction word, NUM_OPS operand channels and an exception flag from one
// stage to the next under a valid/ready handshake. A two-entry skid buffer
// (main + skid) keeps in_ready a pure decode of registered state, so
// back-pressure never forms a combinational path from out_ready to in_ready.
//
// Ports:
//   clk        stage clock
//   reset      synchronous, active-high reset (clears state and data)
//   flush      squash all held entries at the next clk edge
//   in_valid   upstream entry valid
//   in_ready   block can accept this cycle (0 only when both entries held)
//   instr_in   upstream instruction
//   ops_in     packed operands, channel k at [k*DATA_W +: DATA_W]
//   exc_in     upstream exception flag
//   out_valid  head entry valid
//   out_ready  downstream consumes head this cycle
//   instr_out  head instruction, NOP_INSTR when out_valid=0
//   ops_out    head operands (main register contents, even when invalid)
//   exc_out    head exception flag, 0 when out_valid=0
//   write_mem  head is a non-excepting store (opcode instr[31:27]==SW_OPCODE)
//
// Optional build macro PIPE_STAGE_PERF_EN adds three 32-bit wrapping
// performance counters (stall_cnt, bubble_cnt, flush_cnt). They are cleared
// by reset only, never by flush. Core behaviour is identical in both builds.
//------------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          NUM_OPS   = 2,
    parameter logic [DATA_W-1:0]    NOP_INSTR = 32'h0000_0000,
    parameter logic [4:0]           SW_OPCODE = 5'b00111
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           instr_in,
    input  logic [NUM_OPS*DATA_W-1:0]   ops_in,
    input  logic                        exc_in,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           instr_out,
    output logic [NUM_OPS*DATA_W-1:0]   ops_out,
    output logic                        exc_out,
    output logic                        write_mem
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 bubble_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    //--------------------------------------------------------------------------
    // Types
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_FULL  = 2'd1,   // main valid
        ST_SKID  = 2'd2    // main and skid valid
    } state_t;

    // One pipeline entry as it travels between stages.
    typedef struct packed {
        logic [DATA_W-1:0]          instr;
        logic [NUM_OPS*DATA_W-1:0]  ops;
        logic                       exc;
    } entry_t;

    //--------------------------------------------------------------------------
    // State and storage
    //--------------------------------------------------------------------------
    state_t state;
    entry_t main_q;     // head entry, always the one presented downstream
    entry_t skid_q;     // second entry, only meaningful in ST_SKID
    entry_t in_entry;

    logic accept;
    logic consume;

    assign in_entry = '{instr: instr_in, ops: ops_in, exc: exc_in};

    // Handshake decode uses registered state only; out_ready never reaches
    // in_ready, which is the whole point of carrying a skid entry.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);

    assign accept  = in_valid  & in_ready;
    assign consume = out_valid & out_ready;

    //--------------------------------------------------------------------------
    // Control FSM and data registers
    //
    // Data registers load only on an actual transfer so that holding an entry
    // causes no toggling on the wide datapath.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: the two data entries are plain flops, not a RAM, so they are
            // cleared here; this gives instr/ops a known 0 after reset and costs
            // only a reset term on each flop.
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Squash wins over any accept/consume in the same cycle; the data
            // registers keep their contents, only validity is dropped.
            state <= ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= ST_FULL;
                    end
                end

                ST_FULL: begin
                    unique case ({accept, consume})
                        2'b11: main_q <= in_entry;          // stream through
                        2'b01: state  <= ST_EMPTY;          // drain
                        2'b10: begin                        // park in skid
                            skid_q <= in_entry;
                            state  <= ST_SKID;
                        end
                        default: ;                          // hold
                    endcase
                end

                ST_SKID: begin
                    // in_ready is 0 here, so no accept can coincide.
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ST_FULL;
                    end
                end

                default: state <= ST_EMPTY;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Output decode
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output written in this block gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        instr_out = NOP_INSTR;
        exc_out   = 1'b0;
        write_mem = 1'b0;

        if (out_valid) begin
            instr_out = main_q.instr;
            exc_out   = main_q.exc;
            // An excepting store must never reach memory.
            write_mem = (main_q.instr[31:27] == SW_OPCODE) & ~main_q.exc;
        end
    end

    // Operands are shown unqualified; consumers gate them with out_valid.
    assign ops_out = main_q.ops;

`ifdef PIPE_STAGE_PERF_EN
    //--------------------------------------------------------------------------
    // Performance counters: free-running, wrap at 2^32, survive flush.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid & ~out_ready) stall_cnt  <= stall_cnt  + 32'd1;
            if (~out_valid)             bubble_cnt <= bubble_cnt + 32'd1;
            if (flush)                  flush_cnt  <= flush_cnt  + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
//------------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed self-checking bench for pipe_stage_buf. Inputs are driven and
// outputs sampled on the falling edge, half a period away from the active
// rising edge. Each scenario task carries its own hand-computed expectations.
// Observed status vector layout used throughout:
//   {out_valid, in_ready, exc_out, write_mem, instr_out[31:0]}
//------------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 2;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           instr_in;
    logic [NUM_OPS*DATA_W-1:0]   ops_in;
    logic                        exc_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           instr_out;
    logic [NUM_OPS*DATA_W-1:0]   ops_out;
    logic                        exc_out;
    logic                        write_mem;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]                 stall_cnt;
    logic [31:0]                 bubble_cnt;
    logic [31:0]                 flush_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W    (DATA_W),
        .NUM_OPS   (NUM_OPS),
        .NOP_INSTR (NOP),
        .SW_OPCODE (5'b00111)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .ops_in    (ops_in),
        .exc_in    (exc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .ops_out   (ops_out),
        .exc_out   (exc_out),
        .write_mem (write_mem)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Current observed status vector.
    function automatic logic [35:0] status();
        return {out_valid, in_ready, exc_out, write_mem, instr_out};
    endfunction

    // Stimulus helper only: applies upstream inputs (no checking here).
    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic exc, input logic [63:0] ops);
        in_valid = v;
        instr_in = ins;
        exc_in   = exc;
        ops_in   = ops;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        logic [35:0] exp;
        do_reset();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL reset_status: got %h want %h", status(), exp);
        end
        n_vec++;
        if (ops_out !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_ops: got %h want 0", ops_out);
        end
        // Idle a cycle: nothing should appear.
        @(negedge clk);
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want %h", status(), exp);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_streaming();
        logic [31:0] ins [3];
        logic [63:0] ops [3];
        logic        wm  [3];
        logic [35:0] exp;
        ins[0] = 32'h3800_0004; wm[0] = 1'b1; ops[0] = 64'hB000_0001_A000_0001;
        ins[1] = 32'h0000_0005; wm[1] = 1'b0; ops[1] = 64'hB000_0002_A000_0002;
        ins[2] = 32'h0000_0006; wm[2] = 1'b0; ops[2] = 64'hB000_0003_A000_0003;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, ins[0], 1'b0, ops[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, 1'b0, wm[i], ins[i]};
            n_vec++;
            if (status() !== exp) begin
                n_bad++;
                $display("FAIL stream_%0d: got %h want %h", i, status(), exp);
            end
            n_vec++;
            if (ops_out !== ops[i]) begin
                n_bad++;
                $display("FAIL stream_ops_%0d: got %h want %h", i, ops_out, ops[i]);
            end
            if (i < 2) drive(1'b1, ins[i+1], 1'b0, ops[i+1]);
            else       drive(1'b0, 32'h0, 1'b0, 64'h0);
        end
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL stream_drain: got %h want %h", status(), exp);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_back_pressure();
        logic [35:0] exp;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 64'h1111);
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h11};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL bp_first: got %h want %h", status(), exp);
        end
        drive(1'b1, 32'h22, 1'b0, 64'h2222);
        @(negedge clk);
        // Both entries held: in_ready drops, head still A.
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL bp_skid: got %h want %h", status(), exp);
        end
        drive(1'b1, 32'h33, 1'b0, 64'h3333);   // not accepted while in_ready=0
        @(negedge clk);
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL bp_hold: got %h want %h", status(), exp);
        end
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        out_ready = 1'b1;
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h22};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL bp_second: got %h want %h", status(), exp);
        end
        n_vec++;
        if (ops_out !== 64'h2222) begin
            n_bad++;
            $display("FAIL bp_second_ops: got %h want %h", ops_out, 64'h2222);
        end
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL bp_empty: got %h want %h", status(), exp);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_flush();
        logic [35:0] exp;
        do_reset();
        // Fill to SKID.
        out_ready = 1'b0;
        drive(1'b1, 32'h44, 1'b0, 64'h44);
        @(negedge clk);
        drive(1'b1, 32'h55, 1'b0, 64'h55);
        @(negedge clk);
        // Flush with consume and a push attempt in the same cycle.
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h66, 1'b0, 64'h66);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_pre_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL flush_skid: got %h want %h", status(), exp);
        end
        // FULL state, flush with an accept: accepted entry is dropped.
        out_ready = 1'b0;
        drive(1'b1, 32'h3800_0077, 1'b0, 64'h77);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h3800_0088, 1'b0, 64'h88);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL flush_accept: got %h want %h", status(), exp);
        end
        @(negedge clk);
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL flush_no_ghost: got %h want %h", status(), exp);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_exception();
        logic [35:0] exp;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h3800_0000, 1'b1, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h3800_0000};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL exc_store: got %h want %h", status(), exp);
        end
        // Non-store with exception: exc_out high, still no write.
        out_ready = 1'b1;
        drive(1'b1, 32'h0800_0001, 1'b1, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h0800_0001};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL exc_alu: got %h want %h", status(), exp);
        end
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL exc_drain: got %h want %h", status(), exp);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset_mid_transfer();
        logic [35:0] exp;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h99, 1'b0, 64'h99);
        @(negedge clk);
        drive(1'b1, 32'hAA, 1'b0, 64'hAA);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        exp = {1'b0, 1'b1, 1'b0, 1'b0, NOP};
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL rst_mid_status: got %h want %h", status(), exp);
        end
        n_vec++;
        if (ops_out !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_mid_ops: got %h want 0", ops_out);
        end
        @(negedge clk);
        n_vec++;
        if (status() !== exp) begin
            n_bad++;
            $display("FAIL rst_mid_idle: got %h want %h", status(), exp);
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    //--------------------------------------------------------------------------
    task automatic test_perf();
        logic [95:0] got;
        logic [95:0] exp;
        do_reset();
        // Two idle cycles after reset: bubble = 2.
        @(negedge clk);
        @(negedge clk);
        // Push one entry with out_ready low; the push cycle is itself a bubble.
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 64'h0);
        // Four stall cycles, then the flush cycle is the fifth.
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        got = {stall_cnt, bubble_cnt, flush_cnt};
        exp = {32'd5, 32'd3, 32'd1};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL perf_counts: got %h want %h", got, exp);
        end
        @(negedge clk);
        got = {stall_cnt, bubble_cnt, flush_cnt};
        exp = {32'd5, 32'd4, 32'd1};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL perf_after: got %h want %h", got, exp);
        end
    endtask
`endif

    //--------------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 64'h0);

        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_exception();
        test_reset_mid_transfer();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
